// File: rtl/rx_seq_monitor_pkg.sv
// Shared constants for the Aurora RX sequence monitor: default widths and FSM state encodings.
package rx_seq_monitor_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 32;
    localparam int unsigned DEF_CNT_WIDTH       = 32;
    localparam int unsigned DEF_MAX_FRAME_WORDS = 64;

    localparam logic [1:0] SEQMON_IDLE     = 2'd0;
    localparam logic [1:0] SEQMON_IN_FRAME = 2'd1;
    localparam logic [1:0] SEQMON_OVERSIZE = 2'd2;

endpackage

// File: rtl/rx_seq_monitor_if.sv
// AXI-Stream beat without tready; the Aurora RX path never applies backpressure.
interface rx_seq_monitor_if #(
    parameter int unsigned DATA_WIDTH = rx_seq_monitor_pkg::DEF_DATA_WIDTH
);
    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast);
    modport slave  (input  tvalid, input  tdata, input  tlast);
endinterface

// File: rtl/rx_seq_monitor_sat_counter.sv
// Saturating accumulator: adds add_val_i when inc_i, clamps at all-ones, clr_i wins over inc_i.
module rx_seq_monitor_sat_counter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADD_WIDTH = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 inc_i,
    input  logic [ADD_WIDTH-1:0] add_val_i,
    output logic [WIDTH-1:0]     cnt_o
);
    localparam int unsigned SUM_WIDTH = ((WIDTH > ADD_WIDTH) ? WIDTH : ADD_WIDTH) + 1;

    logic [WIDTH-1:0]     cnt_q;
    logic [WIDTH-1:0]     cnt_d;
    logic [SUM_WIDTH-1:0] sum_c;
    logic [SUM_WIDTH-1:0] max_c;

    always_comb begin
        sum_c = SUM_WIDTH'(cnt_q) + SUM_WIDTH'(add_val_i);
        max_c = SUM_WIDTH'({WIDTH{1'b1}});
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (sum_c > max_c) ? {WIDTH{1'b1}} : WIDTH'(sum_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/rx_seq_monitor.sv
// In-line Aurora RX monitor: forwards beats with one cycle of latency and checks the
// per-frame sequence word carried on the tlast beat.
module rx_seq_monitor
    import rx_seq_monitor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int unsigned MAX_FRAME_WORDS = DEF_MAX_FRAME_WORDS
) (
    input  logic                  user_clk,
    input  logic                  sys_reset,
    rx_seq_monitor_if.slave       s_axis,
    rx_seq_monitor_if.master      m_axis,
    input  logic                  ctrl_clear,
    output logic [CNT_WIDTH-1:0]  stat_frames,
    output logic [CNT_WIDTH-1:0]  stat_seq_err,
    output logic [CNT_WIDTH-1:0]  stat_lost,
    output logic [CNT_WIDTH-1:0]  stat_oversize,
    output logic [DATA_WIDTH-1:0] stat_last_seq,
    output logic                  stat_seq_valid
);
    localparam int unsigned WCNT_WIDTH = $clog2(MAX_FRAME_WORDS + 1);

    logic                  tvalid_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tlast_q;

    logic [1:0]            state_q, state_d;
    logic [WCNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] last_seq_q;
    logic                  seq_valid_q;

    logic                  seq_chk_c, frame_done_c, oversize_c;
    logic [DATA_WIDTH-1:0] exp_seq_c, delta_c;
    logic                  seq_err_c, fwd_gap_c;

    // Pass-through register; data is never altered or dropped.
    always_ff @(posedge user_clk) begin
        if (sys_reset) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            tvalid_q <= s_axis.tvalid;
            tdata_q  <= s_axis.tdata;
            tlast_q  <= s_axis.tlast;
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;

    always_ff @(posedge user_clk) begin
        if (sys_reset) begin
            state_q <= SEQMON_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        seq_chk_c    = 1'b0;
        frame_done_c = 1'b0;
        oversize_c   = 1'b0;
        if (s_axis.tvalid) begin
            case (state_q)
                SEQMON_IDLE: begin
                    if (s_axis.tlast) begin
                        seq_chk_c    = 1'b1;
                        frame_done_c = 1'b1;
                    end else begin
                        state_d = SEQMON_IN_FRAME;
                        wcnt_d  = WCNT_WIDTH'(1);
                    end
                end
                SEQMON_IN_FRAME: begin
                    wcnt_d = wcnt_q + WCNT_WIDTH'(1);
                    if (s_axis.tlast) begin
                        seq_chk_c    = 1'b1;
                        frame_done_c = 1'b1;
                        state_d      = SEQMON_IDLE;
                        wcnt_d       = '0;
                    end else if (wcnt_d >= WCNT_WIDTH'(MAX_FRAME_WORDS)) begin
                        state_d    = SEQMON_OVERSIZE;
                        oversize_c = 1'b1;
                    end
                end
                SEQMON_OVERSIZE: begin
                    if (s_axis.tlast) begin
                        frame_done_c = 1'b1;
                        state_d      = SEQMON_IDLE;
                        wcnt_d       = '0;
                    end
                end
                default: begin
                    state_d = SEQMON_IDLE;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

    // Modular distance from the expected number; MSB set means duplicate or backwards step.
    always_comb begin
        exp_seq_c = last_seq_q + DATA_WIDTH'(1);
        delta_c   = s_axis.tdata - exp_seq_c;
        seq_err_c = seq_valid_q && (delta_c != '0);
        fwd_gap_c = seq_err_c && !delta_c[DATA_WIDTH-1];
    end

    // Every checked tlast re-baselines, even alongside a clear.
    always_ff @(posedge user_clk) begin
        if (sys_reset) begin
            last_seq_q  <= '0;
            seq_valid_q <= 1'b0;
        end else if (seq_chk_c) begin
            last_seq_q  <= s_axis.tdata;
            seq_valid_q <= 1'b1;
        end else if (ctrl_clear) begin
            seq_valid_q <= 1'b0;
        end
    end

    assign stat_last_seq  = last_seq_q;
    assign stat_seq_valid = seq_valid_q;

    rx_seq_monitor_sat_counter #(.WIDTH(CNT_WIDTH), .ADD_WIDTH(1)) u_cnt_frames (
        .clk_i(user_clk), .rst_i(sys_reset), .clr_i(ctrl_clear),
        .inc_i(frame_done_c), .add_val_i(1'b1), .cnt_o(stat_frames)
    );

    rx_seq_monitor_sat_counter #(.WIDTH(CNT_WIDTH), .ADD_WIDTH(1)) u_cnt_seq_err (
        .clk_i(user_clk), .rst_i(sys_reset), .clr_i(ctrl_clear),
        .inc_i(seq_chk_c && seq_err_c), .add_val_i(1'b1), .cnt_o(stat_seq_err)
    );

    rx_seq_monitor_sat_counter #(.WIDTH(CNT_WIDTH), .ADD_WIDTH(DATA_WIDTH)) u_cnt_lost (
        .clk_i(user_clk), .rst_i(sys_reset), .clr_i(ctrl_clear),
        .inc_i(seq_chk_c && fwd_gap_c), .add_val_i(delta_c), .cnt_o(stat_lost)
    );

    rx_seq_monitor_sat_counter #(.WIDTH(CNT_WIDTH), .ADD_WIDTH(1)) u_cnt_oversize (
        .clk_i(user_clk), .rst_i(sys_reset), .clr_i(ctrl_clear),
        .inc_i(oversize_c), .add_val_i(1'b1), .cnt_o(stat_oversize)
    );
endmodule

// File: tb/tb_rx_seq_monitor.sv
// Directed bench for rx_seq_monitor: frame table with hand-computed statistics plus
// oversize, clear and mid-frame reset sequences.
module tb_rx_seq_monitor;

    logic        user_clk;
    logic        sys_reset;
    logic        ctrl_clear;
    logic [31:0] stat_frames, stat_seq_err, stat_lost, stat_oversize, stat_last_seq;
    logic        stat_seq_valid;

    int n_checks;
    int n_fail;

    rx_seq_monitor_if #(.DATA_WIDTH(32)) s_if ();
    rx_seq_monitor_if #(.DATA_WIDTH(32)) m_if ();

    rx_seq_monitor #(.DATA_WIDTH(32), .CNT_WIDTH(32), .MAX_FRAME_WORDS(8)) dut (
        .user_clk       (user_clk),
        .sys_reset      (sys_reset),
        .s_axis         (s_if.slave),
        .m_axis         (m_if.master),
        .ctrl_clear     (ctrl_clear),
        .stat_frames    (stat_frames),
        .stat_seq_err   (stat_seq_err),
        .stat_lost      (stat_lost),
        .stat_oversize  (stat_oversize),
        .stat_last_seq  (stat_last_seq),
        .stat_seq_valid (stat_seq_valid)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    typedef struct {
        int unsigned nbeats;
        logic [31:0] seq;
        logic        clr;
        logic [31:0] frames, err, lost, over, last_seq;
        logic        seq_valid;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(int unsigned n, logic [31:0] seq, logic clr,
                                logic [31:0] fr, logic [31:0] er, logic [31:0] lo,
                                logic [31:0] ov, logic [31:0] ls, logic sv);
        row_t r;
        r.nbeats = n; r.seq = seq; r.clr = clr;
        r.frames = fr; r.err = er; r.lost = lo; r.over = ov; r.last_seq = ls; r.seq_valid = sv;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_stats(input string tag, input logic [31:0] fr, input logic [31:0] er,
                               input logic [31:0] lo, input logic [31:0] ov,
                               input logic [31:0] ls, input logic sv);
        check({tag, ".frames"},    64'(stat_frames),    64'(fr));
        check({tag, ".seq_err"},   64'(stat_seq_err),   64'(er));
        check({tag, ".lost"},      64'(stat_lost),      64'(lo));
        check({tag, ".oversize"},  64'(stat_oversize),  64'(ov));
        check({tag, ".last_seq"},  64'(stat_last_seq),  64'(ls));
        check({tag, ".seq_valid"}, 64'(stat_seq_valid), 64'(sv));
    endtask

    // One beat per cycle; inputs change 1 time unit after the edge, outputs sampled there too.
    task automatic beat(input logic v, input logic [31:0] d, input logic l, input logic c);
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tlast  = l;
        ctrl_clear  = c;
        @(posedge user_clk);
        #1;
        check("m_tvalid", 64'(m_if.tvalid), 64'(v));
        check("m_tdata",  64'(m_if.tdata),  64'(d));
        check("m_tlast",  64'(m_if.tlast),  64'(l));
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        ctrl_clear  = 1'b0;
    endtask

    task automatic send_frame(input int unsigned n, input logic [31:0] seq,
                              input logic clr, input logic gap);
        for (int i = 0; i < int'(n); i++) begin
            if (i == int'(n) - 1) beat(1'b1, seq, 1'b1, clr);
            else                  beat(1'b1, 32'hC0DE_0000 | 32'(i), 1'b0, 1'b0);
            if (gap && i == 0) beat(1'b0, 32'h0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        sys_reset   = 1'b1;
        ctrl_clear  = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        repeat (2) @(posedge user_clk);
        #1;
        check("rst.m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst.m_tdata",  64'(m_if.tdata),  64'd0);
        check_stats("rst", 0, 0, 0, 0, 0, 1'b0);
        sys_reset = 1'b0;

        // nbeats, seq, clear-on-last, expected frames/err/lost/over/last_seq/seq_valid
        tbl.push_back(mk(4, 32'd10, 0, 1, 0, 0, 0, 32'd10, 1));
        tbl.push_back(mk(4, 32'd11, 0, 2, 0, 0, 0, 32'd11, 1));
        tbl.push_back(mk(4, 32'd12, 0, 3, 0, 0, 0, 32'd12, 1));
        tbl.push_back(mk(4, 32'd5,  1, 0, 0, 0, 0, 32'd5,  1));
        tbl.push_back(mk(4, 32'd6,  0, 1, 0, 0, 0, 32'd6,  1));
        tbl.push_back(mk(4, 32'd9,  0, 2, 1, 2, 0, 32'd9,  1));
        tbl.push_back(mk(4, 32'd9,  0, 3, 2, 2, 0, 32'd9,  1));
        tbl.push_back(mk(1, 32'hFFFF_FFFE, 0, 4, 3, 2, 0, 32'hFFFF_FFFE, 1));
        tbl.push_back(mk(2, 32'hFFFF_FFFF, 0, 5, 3, 2, 0, 32'hFFFF_FFFF, 1));
        tbl.push_back(mk(4, 32'd0,  0, 6, 3, 2, 0, 32'd0,  1));
        tbl.push_back(mk(3, 32'd1,  0, 7, 3, 2, 0, 32'd1,  1));
        tbl.push_back(mk(4, 32'd40, 1, 0, 0, 0, 0, 32'd40, 1));
        tbl.push_back(mk(4, 32'd41, 0, 1, 0, 0, 0, 32'd41, 1));
        tbl.push_back(mk(4, 32'h0000_1029, 0, 2, 1, 32'h0000_0FFF, 0, 32'h0000_1029, 1));
        tbl.push_back(mk(4, 32'h8000_1029, 0, 3, 2, 32'h8000_0FFE, 0, 32'h8000_1029, 1));
        tbl.push_back(mk(4, 32'h0000_102A, 0, 4, 3, 32'h8000_0FFE, 0, 32'h0000_102A, 1));
        tbl.push_back(mk(4, 32'h8000_102A, 0, 5, 4, 32'hFFFF_FFFF, 0, 32'h8000_102A, 1));
        tbl.push_back(mk(8, 32'h8000_102B, 0, 6, 4, 32'hFFFF_FFFF, 0, 32'h8000_102B, 1));

        foreach (tbl[k]) begin
            send_frame(tbl[k].nbeats, tbl[k].seq, tbl[k].clr, 1'b0);
            check_stats($sformatf("row%0d", k), tbl[k].frames, tbl[k].err, tbl[k].lost,
                        tbl[k].over, tbl[k].last_seq, tbl[k].seq_valid);
        end

        // 12-beat frame with an 8-word limit: counted once as oversize, no sequence check
        send_frame(12, 32'd99, 1'b0, 1'b0);
        check_stats("oversize", 7, 4, 32'hFFFF_FFFF, 1, 32'h8000_102B, 1'b1);
        send_frame(4, 32'h8000_102C, 1'b0, 1'b0);
        check_stats("after_over", 8, 4, 32'hFFFF_FFFF, 1, 32'h8000_102C, 1'b1);

        // Clear with no beat drops the baseline; next frame (with an idle gap) re-baselines
        beat(1'b0, 32'h0, 1'b0, 1'b1);
        check_stats("clear_idle", 0, 0, 0, 0, 32'h8000_102C, 1'b0);
        send_frame(4, 32'd500, 1'b0, 1'b1);
        check_stats("gap_frame", 1, 0, 0, 0, 32'd500, 1'b1);

        // Reset during beat 2 of 4: remaining two beats form a fresh baseline frame
        beat(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        beat(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
        sys_reset   = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'hDEAD_BEEF;
        s_if.tlast  = 1'b0;
        for (int r = 0; r < 2; r++) begin
            @(posedge user_clk);
            #1;
            check("rstmid.m_tvalid", 64'(m_if.tvalid), 64'd0);
            check("rstmid.m_tdata",  64'(m_if.tdata),  64'd0);
            check("rstmid.m_tlast",  64'(m_if.tlast),  64'd0);
            check_stats("rstmid", 0, 0, 0, 0, 0, 1'b0);
        end
        sys_reset   = 1'b0;
        s_if.tvalid = 1'b0;
        beat(1'b1, 32'hAAAA_0003, 1'b0, 1'b0);
        beat(1'b1, 32'd6, 1'b1, 1'b0);
        check_stats("post_rst", 1, 0, 0, 0, 32'd6, 1'b1);
        send_frame(4, 32'd7, 1'b0, 1'b0);
        send_frame(4, 32'd8, 1'b0, 1'b0);
        check_stats("post_rst2", 3, 0, 0, 0, 32'd8, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
